ps2_host_tx: RTL

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the attached keyboard. Drives the open-drain PS/2 clock and data lines through active-high pull-low enables, completes the PS/2 request-to-send sequence, shifts out data, odd parity and stop, and checks the device ACK. It sits beside the existing PS/2 receive path on the same two pads; `busy` lets the top level ignore receiver output while a transmission owns the bus.

---
 rtl/ps2_host_tx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits LSB first, odd parity,
// stop, then device ACK check. Drives the open-drain pads through active-high pull-low enables.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [9:0]    frame_r, frame_s;
  logic [3:0]    bit_cnt_r, bit_cnt_s;
  logic [1:0]    clk_sync_r, data_sync_r;
  logic          clk_prev_r;
  logic          fall_s, to_hit_s, data_oe_s, done_s, err_s;

  assign fall_s   = clk_prev_r & ~clk_sync_r[1];
  assign to_hit_s = (cnt_r == CW'(TIMEOUT_CYCLES - 1));

  // Pad synchronizers; idle bus level is high so reset to 1 to avoid a false falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk_in};
      data_sync_r <= {data_sync_r[0], ps2_data_in};
      clk_prev_r  <= clk_sync_r[1];
    end
  end

  // Next-state, datapath and pulse decode; a falling edge wins over a coinciding timeout.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    frame_s   = frame_r;
    bit_cnt_s = bit_cnt_r;
    data_oe_s = ps2_data_oe;
    done_s    = 1'b0;
    err_s     = 1'b0;
    cnt_inc_s = to_hit_s ? cnt_r : cnt_r + CW'(1);
    case (state_r)
      ST_IDLE: begin
        data_oe_s = 1'b0;
        if (tx_valid && tx_ready) begin
          frame_s   = {1'b1, odd_parity(tx_data), tx_data};
          bit_cnt_s = 4'd0;
          cnt_s     = {CW{1'b0}};
          state_s   = ST_INHIBIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        if (cnt_r == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_s     = {CW{1'b0}};
          data_oe_s = 1'b1;
          state_s   = ST_START;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_START: begin
        cnt_s     = {CW{1'b0}};
        data_oe_s = 1'b1;
        state_s   = ST_SHIFT;
      end
      ST_SHIFT: begin
        cnt_s = cnt_inc_s;
        if (fall_s) begin
          data_oe_s = ~frame_r[0];
          frame_s   = {1'b0, frame_r[9:1]};
          bit_cnt_s = bit_cnt_r + 4'd1;
          if (bit_cnt_r == 4'd9) begin
            state_s = ST_ACK;
          end else begin
            state_s = ST_SHIFT;
          end
        end else if (to_hit_s) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_ACK: begin
        cnt_s = cnt_inc_s;
        if (fall_s) begin
          if (data_sync_r[1] == 1'b0) begin
            state_s = ST_WAIT_IDLE;
          end else begin
            err_s   = 1'b1;
            state_s = ST_IDLE;
          end
        end else if (to_hit_s) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ACK;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_s = cnt_inc_s;
        if (clk_sync_r[1] && data_sync_r[1]) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else if (to_hit_s) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_IDLE;
        end
      end
      default: begin
        data_oe_s = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      frame_r     <= 10'd0;
      bit_cnt_r   <= 4'd0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      frame_r     <= frame_s;
      bit_cnt_r   <= bit_cnt_s;
      ps2_clk_oe  <= (state_s == ST_INHIBIT) || (state_s == ST_START);
      ps2_data_oe <= (state_s == ST_IDLE) ? 1'b0 : data_oe_s;
      tx_ready    <= (state_s == ST_IDLE);
      busy        <= (state_s != ST_IDLE);
      done        <= done_s;
      err         <= err_s;
    end
  end

endmodule
